// File: rtl/apb_master_bridge_pkg.sv
// Shared types and default widths for the APB requester bridge.
// Pulled in by the interface, the bridge and its bench.
package apb_master_bridge_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Host command/response port plus APB3 bus of the bridge.
// master = bridge side, slave = host and APB target side.
interface apb_master_bridge_if
    import apb_master_bridge_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 requester: valid/ready command in, one
// SETUP->ACCESS transfer out, response held until the host takes it.
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    apb_master_bridge_if.master bus
);

    localparam bit TO_EN = (TIMEOUT_CYC > 0);
    localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM =
        CNT_W'(TO_EN ? TIMEOUT_CYC - 1 : 0);

    apb_state_e        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = wait_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_d   = SETUP;
                    pwrite_d  = bus.cmd_write;
                    paddr_d   = bus.cmd_addr;
                    pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end
            end
            SETUP: begin
                state_d    = ACCESS;
                penable_d  = 1'b1;
                wait_cnt_d = '0;
            end
            ACCESS: begin
                // PREADY is checked first so it wins over a same-edge timeout
                if (bus.PREADY) begin
                    state_d       = RESP;
                    rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_d     = bus.PSLVERR;
                    rsp_timeout_d = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                end else if (TO_EN && wait_cnt_q == CNT_LIM) begin
                    state_d       = RESP;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench: bridge plus an 8-entry APB register-file slave
// with programmable ACCESS length and a hang switch.
module tb_apb_master_bridge;
    import apb_master_bridge_pkg::*;

    logic PCLK;
    logic PRESETn;

    apb_master_bridge_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    apb_master_bridge #(.TIMEOUT_CYC(16)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_run  = 0;
    int n_fail = 0;
    apb_rsp_t exp_q[$];

    // slave: n_acc = ACCESS cycles per transfer, hang = never ready
    logic [7:0] regs [8];
    int         acc_cnt;
    int         n_acc;
    bit         hang;

    always_comb begin
        bus.PREADY  = bus.PSEL && bus.PENABLE && !hang &&
                      (acc_cnt >= n_acc - 1);
        bus.PRDATA  = 8'hCC;
        bus.PSLVERR = 1'b1;
        if (bus.PREADY) begin
            bus.PSLVERR = (bus.PADDR >= 8'h08);
            if (bus.PWRITE)
                bus.PRDATA = 8'hFF;
            else if (bus.PADDR < 8'h08)
                bus.PRDATA = regs[bus.PADDR[2:0]];
            else
                bus.PRDATA = 8'h00;
        end
    end

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            acc_cnt <= 0;
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
        end else if (bus.PSEL && bus.PENABLE) begin
            if (bus.PREADY) begin
                acc_cnt <= 0;
                if (bus.PWRITE && bus.PADDR < 8'h08)
                    regs[bus.PADDR[2:0]] <= bus.PWDATA;
            end else begin
                acc_cnt <= acc_cnt + 1;
            end
        end else begin
            acc_cnt <= 0;
        end
    end

    int         psel_cnt = 0;
    int         pen_cnt  = 0;
    int         addr_bad = 0;
    logic [7:0] mon_addr;

    always @(negedge PCLK) begin
        if (bus.PSEL) psel_cnt <= psel_cnt + 1;
        if (bus.PENABLE) pen_cnt <= pen_cnt + 1;
        if (bus.PENABLE && bus.PADDR != mon_addr)
            addr_bad <= addr_bad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic apb_cmd_t mk_cmd(input logic w, input logic [7:0] a,
                                        input logic [7:0] d);
        apb_cmd_t c;
        c.write = w;
        c.addr  = a;
        c.wdata = d;
        return c;
    endfunction

    function automatic apb_rsp_t mk_rsp(input logic [7:0] r, input logic e,
                                        input logic t);
        apb_rsp_t s;
        s.rdata   = r;
        s.err     = e;
        s.timeout = t;
        return s;
    endfunction

    task automatic send(input apb_cmd_t c, input apb_rsp_t e);
        int n;
        @(negedge PCLK);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = c.write;
        bus.cmd_addr  = c.addr;
        bus.cmd_wdata = c.wdata;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        chk("cmd_accept", 32'(bus.cmd_ready), 32'd1);
        exp_q.push_back(e);
        @(posedge PCLK);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 8'hFF;
        bus.cmd_wdata = 8'h5C;
        bus.cmd_write = ~c.write;
    endtask

    task automatic get_rsp(input int hold, output int lat);
        apb_rsp_t e;
        int       n;
        bus.rsp_ready = (hold == 0);
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!bus.rsp_valid && n < 100);
        lat = n;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : mk_rsp(8'hXX, 1'bx, 1'bx);
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.timeout));
        if (hold > 0) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_write = 1'b0;
            bus.cmd_addr  = 8'h01;
            for (int i = 0; i < hold; i++) begin
                @(negedge PCLK);
                chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
                chk("hold_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
                chk("hold_err", 32'(bus.rsp_err), 32'(e.err));
                chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
                chk("hold_psel", 32'(bus.PSEL), 32'd0);
            end
            bus.cmd_valid = 1'b0;
            bus.rsp_ready = 1'b1;
            @(negedge PCLK);
            chk("rel_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
            chk("rel_rdata_kept", 32'(bus.rsp_rdata), 32'(e.rdata));
        end
    endtask

    initial begin
        int lat;
        int ps0;
        int pe0;
        int ab0;
        int n;

        PRESETn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 8'h00;
        bus.rsp_ready = 1'b1;
        n_acc         = 1;
        hang          = 1'b0;
        mon_addr      = 8'h00;

        repeat (3) @(negedge PCLK);
        chk("rst_psel", 32'(bus.PSEL), 32'd0);
        chk("rst_penable", 32'(bus.PENABLE), 32'd0);
        chk("rst_paddr", 32'(bus.PADDR), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        PRESETn = 1'b1;

        // zero-wait write then read back
        #1;
        ps0 = psel_cnt;
        pe0 = pen_cnt;
        send(mk_cmd(1'b1, 8'h03, 8'hA5), mk_rsp(8'h00, 1'b0, 1'b0));
        get_rsp(0, lat);
        #1;
        chk("t1_latency", 32'(lat), 32'd3);
        chk("t1_psel_cycles", 32'(psel_cnt - ps0), 32'd2);
        chk("t1_pen_cycles", 32'(pen_cnt - pe0), 32'd1);
        send(mk_cmd(1'b0, 8'h03, 8'h00), mk_rsp(8'hA5, 1'b0, 1'b0));
        get_rsp(0, lat);
        chk("t1_rd_latency", 32'(lat), 32'd3);

        // fresh reset, then a 4-cycle ACCESS read
        @(negedge PCLK);
        PRESETn = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        n_acc    = 4;
        mon_addr = 8'h05;
        #1;
        pe0 = pen_cnt;
        ab0 = addr_bad;
        send(mk_cmd(1'b0, 8'h05, 8'h00), mk_rsp(8'h00, 1'b0, 1'b0));
        get_rsp(0, lat);
        #1;
        chk("t2_latency", 32'(lat), 32'd6);
        chk("t2_pen_cycles", 32'(pen_cnt - pe0), 32'd4);
        chk("t2_paddr_stable", 32'(addr_bad - ab0), 32'd0);

        // slave error on out-of-range write
        n_acc = 1;
        send(mk_cmd(1'b1, 8'h09, 8'h11), mk_rsp(8'h00, 1'b1, 1'b0));
        get_rsp(0, lat);
        send(mk_cmd(1'b0, 8'h01, 8'h00), mk_rsp(8'h00, 1'b0, 1'b0));
        get_rsp(0, lat);

        // PREADY on the 16th ACCESS cycle still completes normally
        send(mk_cmd(1'b1, 8'h07, 8'h3C), mk_rsp(8'h00, 1'b0, 1'b0));
        get_rsp(0, lat);
        n_acc = 16;
        #1;
        pe0 = pen_cnt;
        send(mk_cmd(1'b0, 8'h07, 8'h00), mk_rsp(8'h3C, 1'b0, 1'b0));
        get_rsp(0, lat);
        #1;
        chk("t4_edge_pen", 32'(pen_cnt - pe0), 32'd16);

        // hung slave: abort after 16 ACCESS cycles
        hang = 1'b1;
        #1;
        pe0 = pen_cnt;
        send(mk_cmd(1'b1, 8'h04, 8'h99), mk_rsp(8'h00, 1'b1, 1'b1));
        get_rsp(0, lat);
        #1;
        chk("t4_to_pen", 32'(pen_cnt - pe0), 32'd16);
        chk("t4_to_psel", 32'(bus.PSEL), 32'd0);
        chk("t4_to_penable", 32'(bus.PENABLE), 32'd0);
        hang  = 1'b0;
        n_acc = 1;
        send(mk_cmd(1'b0, 8'h04, 8'h00), mk_rsp(8'h00, 1'b0, 1'b0));
        get_rsp(0, lat);

        // host back-pressure on the response
        send(mk_cmd(1'b1, 8'h06, 8'h5A), mk_rsp(8'h00, 1'b0, 1'b0));
        get_rsp(5, lat);
        send(mk_cmd(1'b0, 8'h06, 8'h00), mk_rsp(8'h5A, 1'b0, 1'b0));
        get_rsp(0, lat);

        // asynchronous reset while stuck in ACCESS
        hang = 1'b1;
        send(mk_cmd(1'b1, 8'h02, 8'h77), mk_rsp(8'h00, 1'b0, 1'b0));
        n = 0;
        while (!bus.PENABLE && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        chk("t6_in_access", 32'(bus.PENABLE), 32'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("t6_psel", 32'(bus.PSEL), 32'd0);
        chk("t6_penable", 32'(bus.PENABLE), 32'd0);
        chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t6_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        void'(exp_q.pop_back());
        hang = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        n_acc   = 2;
        send(mk_cmd(1'b1, 8'h02, 8'h77), mk_rsp(8'h00, 1'b0, 1'b0));
        get_rsp(0, lat);
        chk("t6_latency", 32'(lat), 32'd4);
        send(mk_cmd(1'b0, 8'h02, 8'h00), mk_rsp(8'h77, 1'b0, 1'b0));
        get_rsp(0, lat);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
